// File: rtl/keycode_event_queue.sv
// Turns the level-style PIO keycode into a FIFO of ordered release/press events.
// Optional auto-repeat presses are enabled by defining KEYQ_REPEAT_EN.
module keycode_event_queue #(
    parameter int STABLE_CYCLES = 16,
    parameter int DEPTH         = 8,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [7:0]               keycode,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [7:0]               ev_code,
    output logic                     ev_press,
    output logic                     ev_repeat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] SCNT_MAX = SW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, EMIT_REL = 2'd1, EMIT_PRS = 2'd2} state_t;

    state_t          state_r;
    logic [7:0]      cand_r, cur_r, old_r, nxt_r;
    logic [SW-1:0]   scnt_r;
    logic            stable_s, accept_s, rfire_s;
    logic            push_s, push_ok_s, pop_s, drop_s, full_s;
    logic [9:0]      push_data_s, head_next_s;
    logic [9:0]      mem_r [DEPTH];
    logic [CW-1:0]   wr_ptr_r, rd_ptr_r, rd_next_s, count_next_s;
    logic [AW-1:0]   wr_idx_s, rd_next_idx_s;
    logic            repeat_on_s;

    assign stable_s = (keycode == cand_r) && (scnt_r == SCNT_MAX);
    assign accept_s = (state_r == IDLE) && stable_s && (cand_r != cur_r);

    // Debounce filter: restart the hold count whenever the PIO value moves.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cand_r <= 8'h00;
            scnt_r <= {SW{1'b0}};
        end else if (keycode != cand_r) begin
            cand_r <= keycode;
            scnt_r <= {SW{1'b0}};
        end else if (scnt_r != SCNT_MAX) begin
            scnt_r <= scnt_r + SW'(1);
        end else begin
            scnt_r <= scnt_r;
        end
    end

`ifdef KEYQ_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt_r;
    logic          rfirst_r;

    assign repeat_on_s = 1'b1;

    // Repeat fires only from a settled IDLE with a key held and nothing to accept.
    always_comb begin
        rfire_s = 1'b0;
        if ((state_r == IDLE) && (cur_r != 8'h00) && !accept_s) begin
            rfire_s = rfirst_r ? (rcnt_r == R_DELAY_LAST) : (rcnt_r == R_PERIOD_LAST);
        end else begin
            rfire_s = 1'b0;
        end
    end

    // Repeat timer: long delay before the first repeat, short period afterwards.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rcnt_r   <= {RW{1'b0}};
            rfirst_r <= 1'b1;
        end else if (accept_s || (cur_r == 8'h00)) begin
            rcnt_r   <= {RW{1'b0}};
            rfirst_r <= 1'b1;
        end else if (rfire_s) begin
            rcnt_r   <= {RW{1'b0}};
            rfirst_r <= 1'b0;
        end else if (state_r == IDLE) begin
            rcnt_r   <= rcnt_r + RW'(1);
        end else begin
            rcnt_r   <= rcnt_r;
        end
    end
`else
    logic unused_repeat_s;
    assign unused_repeat_s = (REPEAT_DELAY == 0) ^ (REPEAT_PERIOD == 0);
    assign rfire_s         = 1'b0;
    assign repeat_on_s     = 1'b0;
`endif

    // Event sequencer: one release and/or one press per accepted change.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            cur_r   <= 8'h00;
            old_r   <= 8'h00;
            nxt_r   <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        old_r   <= cur_r;
                        cur_r   <= cand_r;
                        nxt_r   <= cand_r;
                        state_r <= (cur_r != 8'h00) ? EMIT_REL : EMIT_PRS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EMIT_REL: state_r <= (nxt_r != 8'h00) ? EMIT_PRS : IDLE;
                EMIT_PRS: state_r <= IDLE;
                default:  state_r <= IDLE;
            endcase
        end
    end

    // Push request and payload {repeat, press, code} from the sequencer state.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = 10'h000;
        case (state_r)
            IDLE: begin
                if (rfire_s) begin
                    push_s      = 1'b1;
                    push_data_s = {2'b11, cur_r};
                end else begin
                    push_s      = 1'b0;
                end
            end
            EMIT_REL: begin
                push_s      = 1'b1;
                push_data_s = {2'b00, old_r};
            end
            EMIT_PRS: begin
                push_s      = 1'b1;
                push_data_s = {2'b01, nxt_r};
            end
            default: push_s = 1'b0;
        endcase
    end

    assign full_s        = (count == CW'(DEPTH));
    assign pop_s         = ev_valid && ev_ready;
    assign push_ok_s     = push_s && (!full_s || pop_s);
    assign drop_s        = push_s && !push_ok_s;
    assign wr_idx_s      = wr_ptr_r[AW-1:0];
    assign rd_next_s     = rd_ptr_r + CW'(pop_s);
    assign rd_next_idx_s = rd_next_s[AW-1:0];
    assign count_next_s  = count + CW'(push_ok_s) - CW'(pop_s);
    // Indices only collide when the queue drains to empty, so the push becomes the head.
    assign head_next_s   = (push_ok_s && (wr_idx_s == rd_next_idx_s)) ? push_data_s
                                                                       : mem_r[rd_next_idx_s];

    // FIFO storage, pointers, registered head view and sticky overflow.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 10'h000;
            wr_ptr_r  <= {CW{1'b0}};
            rd_ptr_r  <= {CW{1'b0}};
            count     <= {CW{1'b0}};
            ev_valid  <= 1'b0;
            ev_code   <= 8'h00;
            ev_press  <= 1'b0;
            ev_repeat <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_idx_s] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + CW'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            rd_ptr_r <= rd_next_s;
            count    <= count_next_s;
            if (count_next_s != {CW{1'b0}}) begin
                ev_valid  <= 1'b1;
                ev_code   <= head_next_s[7:0];
                ev_press  <= head_next_s[8];
                ev_repeat <= head_next_s[9] & repeat_on_s;
            end else begin
                ev_valid  <= 1'b0;
                ev_code   <= 8'h00;
                ev_press  <= 1'b0;
                ev_repeat <= 1'b0;
            end
            if (drop_s)       overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            else              overflow <= overflow;
        end
    end
endmodule

// File: tb/tb_keycode_event_queue.sv
// Scoreboard bench for keycode_event_queue (STABLE_CYCLES=4, DEPTH=4).
module tb_keycode_event_queue;
    logic       Clk;
    logic       Reset_n;
    logic [7:0] keycode;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_press;
    logic       ev_repeat;
    logic [2:0] count;
    logic       overflow;
    logic       ovf_clr;

    keycode_event_queue #(
        .STABLE_CYCLES(4), .DEPTH(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_press(ev_press), .ev_repeat(ev_repeat), .count(count),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [9:0] exp_q[$];
    int         pop_cyc[$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Every dequeued head must match the oldest expected event.
    always @(negedge Clk) begin
        if (Reset_n && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_event", {22'd0, ev_repeat, ev_press, ev_code}, 32'd0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check_eq("event", {22'd0, ev_repeat, ev_press, ev_code}, {22'd0, e});
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int maxc;
        Reset_n  = 1'b0;
        keycode  = 8'h00;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        tick(2);
        check_eq("reset_outs", {20'd0, ev_valid, ev_press, ev_repeat, overflow, count, ev_code}, 32'd0);
        Reset_n = 1'b1;
        tick(6);
        check_eq("post_reset_outs", {20'd0, ev_valid, ev_press, ev_repeat, overflow, count, ev_code}, 32'd0);

        // Single key, consumer always ready: valid exactly 6 cycles after the change.
        ev_ready = 1'b1;
        keycode  = 8'h1A;
        exp_q.push_back({2'b01, 8'h1A});
        tick(5);
        check_eq("t1_valid_early", {31'd0, ev_valid}, 32'd0);
        tick(1);
        check_eq("t1_valid_on_time", {31'd0, ev_valid}, 32'd1);
        check_eq("t1_head_code", {24'd0, ev_code}, 32'h1A);
        tick(4);
        keycode = 8'h00;
        exp_q.push_back({2'b00, 8'h1A});
        tick(10);
        check_eq("t1_count_end", {29'd0, count}, 32'd0);

        // Glitch rejection: 3-cycle transient produces nothing.
        maxc    = 0;
        keycode = 8'h07;
        tick(3);
        keycode = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (int'(count) > maxc) maxc = int'(count);
        end
        check_eq("t2_glitch_count", maxc, 32'd0);

        // Direct change 0x04 -> 0x16: release then press on consecutive pushes.
        keycode = 8'h04;
        exp_q.push_back({2'b01, 8'h04});
        tick(8);
        ev_ready = 1'b0;
        keycode  = 8'h16;
        exp_q.push_back({2'b00, 8'h04});
        exp_q.push_back({2'b01, 8'h16});
        tick(5);
        check_eq("t3_count_before", {29'd0, count}, 32'd0);
        tick(1);
        check_eq("t3_count_first", {29'd0, count}, 32'd1);
        tick(1);
        check_eq("t3_count_second", {29'd0, count}, 32'd2);
        check_eq("t3_head", {23'd0, ev_press, ev_code}, {23'd0, 1'b0, 8'h04});
        tick(2);
        check_eq("t3_head_held", {22'd0, ev_valid, ev_press, ev_code}, {22'd0, 1'b1, 1'b0, 8'h04});
        ev_ready = 1'b1;
        tick(3);
        check_eq("t3_drained", {29'd0, count}, 32'd0);

        // Overflow: five events into a four-entry queue with the consumer stalled.
        ev_ready = 1'b0;
        keycode  = 8'h21;
        exp_q.push_back({2'b00, 8'h16});
        exp_q.push_back({2'b01, 8'h21});
        tick(8);
        keycode = 8'h22;
        exp_q.push_back({2'b00, 8'h21});
        exp_q.push_back({2'b01, 8'h22});
        tick(8);
        check_eq("t4_no_ovf_yet", {31'd0, overflow}, 32'd0);
        keycode = 8'h00;
        tick(8);
        check_eq("t4_count_full", {29'd0, count}, 32'd4);
        check_eq("t4_overflow", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check_eq("t4_ovf_clr", {31'd0, overflow}, 32'd0);
        ev_ready = 1'b1;
        tick(6);
        check_eq("t4_drained", {29'd0, count}, 32'd0);

        // Full queue with a pop and push landing on the same edge.
        ev_ready = 1'b0;
        keycode  = 8'h31;
        exp_q.push_back({2'b01, 8'h31});
        tick(8);
        keycode = 8'h32;
        exp_q.push_back({2'b00, 8'h31});
        exp_q.push_back({2'b01, 8'h32});
        tick(8);
        keycode = 8'h00;
        exp_q.push_back({2'b00, 8'h32});
        tick(8);
        check_eq("t5_full", {29'd0, count}, 32'd4);
        keycode = 8'h41;
        exp_q.push_back({2'b01, 8'h41});
        tick(5);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        check_eq("t5_count_kept", {29'd0, count}, 32'd4);
        check_eq("t5_no_overflow", {31'd0, overflow}, 32'd0);
        check_eq("t5_new_head", {23'd0, ev_press, ev_code}, {23'd0, 1'b0, 8'h31});
        ev_ready = 1'b1;
        keycode  = 8'h00;
        exp_q.push_back({2'b00, 8'h41});
        tick(12);
        check_eq("t5_drained", {29'd0, count}, 32'd0);
        check_eq("t5_ovf_end", {31'd0, overflow}, 32'd0);

        // Reset mid-operation discards queued events.
        ev_ready = 1'b0;
        keycode  = 8'h55;
        tick(8);
        check_eq("rst_pre_count", {29'd0, count}, 32'd1);
        Reset_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", {20'd0, ev_valid, ev_press, ev_repeat, overflow, count, ev_code}, 32'd0);
        keycode = 8'h00;
        tick(2);
        Reset_n = 1'b1;
        tick(1);
        check_eq("rst_after_outs", {20'd0, ev_valid, ev_press, ev_repeat, overflow, count, ev_code}, 32'd0);
        tick(10);
        check_eq("rst_still_empty", {29'd0, count}, 32'd0);

`ifdef KEYQ_REPEAT_EN
        // Auto-repeat: first repeat 20 cycles after the press, then every 8.
        ev_ready = 1'b1;
        pop_cyc.delete();
        keycode = 8'h1A;
        exp_q.push_back({2'b01, 8'h1A});
        exp_q.push_back({2'b11, 8'h1A});
        exp_q.push_back({2'b11, 8'h1A});
        tick(40);
        check_eq("t6_event_count", pop_cyc.size(), 32'd3);
        if (pop_cyc.size() == 3) begin
            check_eq("t6_first_gap", pop_cyc[1] - pop_cyc[0], 32'd20);
            check_eq("t6_period_gap", pop_cyc[2] - pop_cyc[1], 32'd8);
        end
        Reset_n = 1'b0;
        #1;
        check_eq("t6_rst_outs", {20'd0, ev_valid, ev_press, ev_repeat, overflow, count, ev_code}, 32'd0);
        keycode = 8'h00;
        tick(2);
        Reset_n = 1'b1;
        tick(1);
        check_eq("t6_after_rst", {20'd0, ev_valid, ev_press, ev_repeat, overflow, count, ev_code}, 32'd0);
        tick(4);
`endif

        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
